vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator. It is the successor to controlVGA, and adds the following:
- Per-axis timing parameters.
- Configurable sync polarity.
- An integer pixel-clock divider.
- Pixel/line/frame strobes.
- An enable that freezes the raster.

It sits between the system clock domain and the DAC pins. A pixel source reads h_count/v_count and drives pix_r/g/b; this block blanks that colour and emits sync.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 56 +++++
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared types and helpers for the VGA raster timing generator.
//   vga_axis_t     - per-axis timing (active, front porch, sync, back porch)
//   VGA_640x480_*  - standard 640x480@60 axis timings
//   axis_total()   - total length of one axis (active+fp+sync+bp)
//   count_width()  - counter width able to hold 0..total-1 (at least 1 bit)
package vga_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } vga_axis_t;

    localparam vga_axis_t VGA_640x480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam vga_axis_t VGA_640x480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

    function automatic int unsigned axis_total(input vga_axis_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

    function automatic int unsigned count_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
//   clk, reset      - system clock, synchronous active-high reset
//   step            - advance the count by one on this edge
//   count           - current position, 0..TOTAL-1
//   next_count      - value count takes on the next edge
//   wrap            - this edge takes count from TOTAL-1 back to 0
//   next_in_sync    - next_count lies inside the sync pulse
//   next_in_active  - next_count lies inside the visible region
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter vga_axis_t AXIS = VGA_640x480_H,
    localparam int unsigned TOTAL = axis_total(AXIS),
    localparam int unsigned W = count_width(TOTAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    output logic [W-1:0] count,
    output logic [W-1:0] next_count,
    output logic         wrap,
    output logic         next_in_sync,
    output logic         next_in_active
);

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam int unsigned  SYNC_START = AXIS.active + AXIS.fp;
    localparam int unsigned  SYNC_END   = AXIS.active + AXIS.fp + AXIS.sync;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    int unsigned  next_u;

    always_comb begin
        wrap    = step && (count_q == LAST);
        count_d = count_q;
        if (step) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
        next_u         = 32'(count_d);
        next_in_sync   = (next_u >= SYNC_START) && (next_u < SYNC_END);
        next_in_active = (next_u < AXIS.active);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign next_count = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   clk, reset            - system clock, synchronous active-high reset
//   v_enable              - 1 runs the raster, 0 freezes all state
//   pix_r/pix_g/pix_b     - colour for the current (horiz_count, vert_count)
//   horiz_count/vert_count- current pixel column / line, zero-extended to CW
//   R/G/B                 - colour blanked outside the active area
//   horiz_sync/vert_sync  - syncs, asserted level HS_POL / VS_POL
//   vga_blank             - DAC BLANK_N (1 = active area)
//   vga_sync              - DAC SYNC_N, tied low
//   clkVGA                - pixel clock to the DAC, CLK_DIV clk per period
//   pix_tick              - one-clk strobe on the edge the counters advance
//   line_start/frame_start- one-clk pulses after a line / frame wrap
//   active                - current position is inside the visible area
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          v_enable,
    input  logic [7:0]    pix_r,
    input  logic [7:0]    pix_g,
    input  logic [7:0]    pix_b,
    output logic [CW-1:0] horiz_count,
    output logic [CW-1:0] vert_count,
    output logic [7:0]    R,
    output logic [7:0]    G,
    output logic [7:0]    B,
    output logic          horiz_sync,
    output logic          vert_sync,
    output logic          vga_blank,
    output logic          vga_sync,
    output logic          clkVGA,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start,
    output logic          active
);

    localparam vga_axis_t   H_AXIS = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam vga_axis_t   V_AXIS = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int unsigned HW     = count_width(axis_total(H_AXIS));
    localparam int unsigned VW     = count_width(axis_total(V_AXIS));
    localparam int unsigned DW     = count_width(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be >= 2");
    end

    logic [DW-1:0] div_q, div_d;
    logic          clk_vga_q, clk_vga_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active_q, active_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    logic [HW-1:0] h_count, h_next;
    logic [VW-1:0] v_count, v_next;
    logic          h_wrap, h_in_sync, h_in_active;
    logic          v_wrap, v_in_sync, v_in_active;
    logic          unused_next;

    assign pix_tick = v_enable && (div_q == DIV_LAST);

    vga_axis_counter #(.AXIS(H_AXIS)) u_h (
        .clk            (clk),
        .reset          (reset),
        .step           (pix_tick),
        .count          (h_count),
        .next_count     (h_next),
        .wrap           (h_wrap),
        .next_in_sync   (h_in_sync),
        .next_in_active (h_in_active)
    );

    vga_axis_counter #(.AXIS(V_AXIS)) u_v (
        .clk            (clk),
        .reset          (reset),
        .step           (h_wrap),
        .count          (v_count),
        .next_count     (v_next),
        .wrap           (v_wrap),
        .next_in_sync   (v_in_sync),
        .next_in_active (v_in_active)
    );

    // next_count is only needed by the per-axis decode inside the counters
    assign unused_next = ^{h_next, v_next};

    always_comb begin
        div_d = div_q;
        if (v_enable) begin
            div_d = pix_tick ? '0 : div_q + 1'b1;
        end
        // Low for the first half of each pixel, so it falls with the counter update
        clk_vga_d = (div_d >= DIV_HALF);
    end

    // Registered from next-state decode so they change on the counter edge
    always_comb begin
        hsync_d       = h_in_sync ? HS_POL : ~HS_POL;
        vsync_d       = v_in_sync ? VS_POL : ~VS_POL;
        active_d      = h_in_active && v_in_active;
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            clk_vga_q     <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            active_q      <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            clk_vga_q     <= clk_vga_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign horiz_count = CW'(h_count);
    assign vert_count  = CW'(v_count);
    assign R           = active_q ? pix_r : '0;
    assign G           = active_q ? pix_g : '0;
    assign B           = active_q ? pix_b : '0;
    assign horiz_sync  = hsync_q;
    assign vert_sync   = vsync_q;
    assign vga_blank   = active_q;
    assign vga_sync    = 1'b0;
    assign clkVGA      = clk_vga_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign active      = active_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;  // 15
    localparam int VT = VA + VF + VS + VB;  // 8

    logic       clk = 1'b0;
    logic       reset;
    logic       v_enable;
    logic [7:0] pix_r, pix_g, pix_b;

    logic [15:0] horiz_count, vert_count;
    logic [7:0]  R, G, B;
    logic        horiz_sync, vert_sync, vga_blank, vga_sync, clkVGA;
    logic        pix_tick, line_start, frame_start, active;

    logic [15:0] horiz_count_p, vert_count_p;
    logic [7:0]  R_p, G_p, B_p;
    logic        horiz_sync_p, vert_sync_p, vga_blank_p, vga_sync_p, clkVGA_p;
    logic        pix_tick_p, line_start_p, frame_start_p, active_p;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned low_cnt;
    int unsigned fs_cnt;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(16)
    ) dut (
        .clk(clk), .reset(reset), .v_enable(v_enable),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .horiz_count(horiz_count), .vert_count(vert_count),
        .R(R), .G(G), .B(B),
        .horiz_sync(horiz_sync), .vert_sync(vert_sync),
        .vga_blank(vga_blank), .vga_sync(vga_sync), .clkVGA(clkVGA),
        .pix_tick(pix_tick), .line_start(line_start),
        .frame_start(frame_start), .active(active)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(16)
    ) dut_pol (
        .clk(clk), .reset(reset), .v_enable(v_enable),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .horiz_count(horiz_count_p), .vert_count(vert_count_p),
        .R(R_p), .G(G_p), .B(B_p),
        .horiz_sync(horiz_sync_p), .vert_sync(vert_sync_p),
        .vga_blank(vga_blank_p), .vga_sync(vga_sync_p), .clkVGA(clkVGA_p),
        .pix_tick(pix_tick_p), .line_start(line_start_p),
        .frame_start(frame_start_p), .active(active_p)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // k: enabled clk edges since reset release; last_en: previous edge was enabled
    task automatic check_model(input int k, input bit last_en, input bit en);
        int p      = k / 2;
        int mh     = p % HT;
        int mv     = (p / HT) % VT;
        bit div1   = (k % 2) == 1;
        bit in_act = (mh < HA) && (mv < VA);
        bit hs_in  = (mh >= HA + HF) && (mh < HA + HF + HS);
        bit vs_in  = (mv >= VA + VF) && (mv < VA + VF + VS);
        bit ls     = last_en && (k > 0) && !div1 && (mh == 0);
        bit fs     = ls && (mv == 0);
        chk("horiz_count", 32'(horiz_count), 32'(mh));
        chk("vert_count",  32'(vert_count),  32'(mv));
        chk("horiz_sync",  32'(horiz_sync),  32'(!hs_in));
        chk("vert_sync",   32'(vert_sync),   32'(!vs_in));
        chk("active",      32'(active),      32'(in_act));
        chk("vga_blank",   32'(vga_blank),   32'(in_act));
        chk("R",           32'(R),           in_act ? 32'hAA : 32'h0);
        chk("G",           32'(G),           in_act ? 32'h55 : 32'h0);
        chk("B",           32'(B),           in_act ? 32'h3C : 32'h0);
        chk("clkVGA",      32'(clkVGA),      32'(div1));
        chk("pix_tick",    32'(pix_tick),    32'(en && div1));
        chk("line_start",  32'(line_start),  32'(ls));
        chk("frame_start", 32'(frame_start), 32'(fs));
        chk("vga_sync",    32'(vga_sync),    32'h0);
        chk("hsync_pol1",  32'(horiz_sync_p), 32'(hs_in));
        chk("vsync_pol1",  32'(vert_sync_p),  32'(vs_in));
    endtask

    initial begin
        reset    = 1'b1;
        v_enable = 1'b1;
        pix_r    = 8'hAA;
        pix_g    = 8'h55;
        pix_b    = 8'h3C;

        // reset held 3 clk
        repeat (3) tick();
        check_model(0, 1'b0, 1'b1);

        reset   = 1'b0;
        low_cnt = 0;
        fs_cnt  = 0;
        for (int k = 1; k <= 246; k++) begin
            tick();
            check_model(k, 1'b1, 1'b1);
            if (k <= 30 && horiz_sync === 1'b0) low_cnt++;
            if (frame_start === 1'b1) fs_cnt++;
            if (k == 20) chk("h_at_clk20", 32'(horiz_count), 32'd10);
            if (k == 30) begin
                chk("line_start_clk30", 32'(line_start), 32'd1);
                chk("v_at_clk30", 32'(vert_count), 32'd1);
            end
            if (k == 240) chk("frame_start_clk240", 32'(frame_start), 32'd1);
        end
        chk("hsync_low_clks", low_cnt, 32'd6);
        chk("frame_start_pulses", fs_cnt, 32'd1);

        // freeze at h=3 for 7 clk
        v_enable = 1'b0;
        #1;
        check_model(246, 1'b1, 1'b0);
        repeat (7) begin
            tick();
            check_model(246, 1'b0, 1'b0);
        end
        v_enable = 1'b1;
        #1;
        check_model(246, 1'b0, 1'b1);
        tick();
        check_model(247, 1'b1, 1'b1);
        tick();
        check_model(248, 1'b1, 1'b1);
        chk("h_after_resume", 32'(horiz_count), 32'd4);

        // run to h=12, v=6 in the next frame
        for (int k = 249; k <= 444; k++) begin
            tick();
            check_model(k, 1'b1, 1'b1);
        end
        chk("h_before_reset", 32'(horiz_count), 32'd12);
        chk("v_before_reset", 32'(vert_count), 32'd6);

        // mid-frame reset
        reset = 1'b1;
        tick();
        check_model(0, 1'b0, 1'b1);
        chk("clkVGA_pol1_reset", 32'(clkVGA_p), 32'd0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
